alu_muldiv_seq: RTL and testbench

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

---
 rtl/alu_muldiv_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequential 8-bit multiply / divide engine that borrows an external shared ALU.
// Multiply is repeated addition; divide is repeated subtraction until a borrow.
module alu_muldiv_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic [2:0] alu_operation,
  output logic       alu_enable,
  input  logic [7:0] alu_result,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_lo,
  output logic [7:0] result_hi,
  output logic       div_by_zero
);

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  // Iteration count while multiplying, running quotient while dividing.
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] res_lo_q, res_lo_d;
  logic [7:0] res_hi_q, res_hi_d;
  logic       dbz_q, dbz_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cnt_q    <= 8'h00;
      rem_q    <= 8'h00;
      res_lo_q <= 8'h00;
      res_hi_q <= 8'h00;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b == 8'h00) state_d = S_DONE;
          else if (op)    state_d = S_DIV;
          else            state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == 8'd1) state_d = S_DONE;
      end
      S_DIV: begin
        // A result larger than the remainder means the subtraction borrowed.
        if (alu_result > rem_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          res_lo_d = 8'h00;
          res_hi_d = 8'h00;
          dbz_d    = 1'b0;
          if (op) begin
            rem_d = a;
            cnt_d = 8'h00;
            if (b == 8'h00) begin
              dbz_d    = 1'b1;
              res_lo_d = 8'hFF;
              res_hi_d = a;
            end
          end else begin
            cnt_d = b;
          end
        end
      end
      S_MUL: begin
        res_lo_d = alu_result;
        // Wrap-around of the low byte is the carry into the high byte.
        if (alu_result < res_lo_q) res_hi_d = res_hi_q + 8'd1;
        cnt_d = cnt_q - 8'd1;
      end
      S_DIV: begin
        if (alu_result <= rem_q) begin
          rem_d = alu_result;
          cnt_d = cnt_q + 8'd1;
        end else begin
          res_lo_d = cnt_q;
          res_hi_d = rem_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    alu_operand1  = 8'h00;
    alu_operand2  = 8'h00;
    alu_operation = ALU_NOP;
    alu_enable    = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    case (state_q)
      S_MUL: begin
        alu_operand1  = res_lo_q;
        alu_operand2  = a_q;
        alu_operation = ALU_ADD;
        alu_enable    = 1'b1;
      end
      S_DIV: begin
        alu_operand1  = rem_q;
        alu_operand2  = b_q;
        alu_operation = ALU_SUB;
        alu_enable    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table of multiply/divide cases plus
// hand-written sequences for ignored starts and reset during an operation.
module tb_alu_muldiv_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] alu_operand1;
  logic [7:0] alu_operand2;
  logic [2:0] alu_operation;
  logic       alu_enable;
  logic [7:0] alu_result;
  logic       busy;
  logic       done;
  logic [7:0] result_lo;
  logic [7:0] result_hi;
  logic       div_by_zero;

  int n_checks;
  int n_errors;
  logic [15:0] exp_q[$];

  typedef struct {
    string      name;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_lo;
    logic [7:0] exp_hi;
    logic       exp_dbz;
    int         exp_done_cyc;
    int         exp_en_cyc;
  } vec_t;

  vec_t vecs[12];

  alu_muldiv_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_operation(alu_operation),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .busy         (busy),
    .done         (done),
    .result_lo    (result_lo),
    .result_hi    (result_hi),
    .div_by_zero  (div_by_zero)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shared ALU
  always_comb begin
    alu_result = 8'h00;
    if (alu_enable) begin
      case (alu_operation)
        3'b011:  alu_result = alu_operand1 + alu_operand2;
        3'b100:  alu_result = alu_operand1 - alu_operand2;
        default: alu_result = 8'h00;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {alu_operand1, alu_operand2, alu_operation, alu_enable,
            busy, done, div_by_zero, 1'b0};
  endfunction

  // Driver: issue one operation, optionally re-pulsing start at two cycles
  // with different operands, then track done timing, ALU usage and results.
  task automatic run_op(input vec_t v, input int poke_a, input int poke_b);
    int   cyc;
    int   en_cnt;
    bit   seen;
    bit   alu_bad;
    bit   busy_bad;
    logic [15:0] exp_res;
    logic [7:0]  held_lo;
    logic [7:0]  held_hi;
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    exp_q.push_back({v.exp_hi, v.exp_lo});
    en_cnt   = 0;
    seen     = 1'b0;
    alu_bad  = 1'b0;
    busy_bad = 1'b0;
    cyc      = 0;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_a || cyc == poke_b) begin
        start = 1'b1;
        op    = ~v.op;
        a     = 8'hA5;
        b     = 8'h03;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_bad = 1'b1;
      if (alu_enable) begin
        en_cnt++;
        if (alu_operation !== (v.op ? 3'b100 : 3'b011)) alu_bad = 1'b1;
        if (alu_operand2 !== (v.op ? v.b : v.a)) alu_bad = 1'b1;
      end else if (alu_operation !== 3'b000 || alu_operand1 !== 8'h00 ||
                   alu_operand2 !== 8'h00) begin
        alu_bad = 1'b1;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check({v.name, " done_timeout"}, 32'(cyc), 32'(v.exp_done_cyc));
      void'(exp_q.pop_front());
      start = 1'b0;
      return;
    end
    exp_res = exp_q.pop_front();
    check({v.name, " done_cycle"}, 32'(cyc), 32'(v.exp_done_cyc));
    check({v.name, " result"}, {16'h0, result_hi, result_lo}, {16'h0, exp_res});
    check({v.name, " div_by_zero"}, 32'(div_by_zero), 32'(v.exp_dbz));
    check({v.name, " alu_enable_cycles"}, 32'(en_cnt), 32'(v.exp_en_cyc));
    check({v.name, " alu_drive"}, 32'(alu_bad), 32'd0);
    check({v.name, " busy_during_op"}, 32'(busy_bad), 32'd0);
    held_lo = result_lo;
    held_hi = result_hi;
    @(negedge clk);
    start = 1'b0;
    check({v.name, " idle_after_done"}, {30'h0, busy, done}, 32'd0);
    @(negedge clk);
    check({v.name, " result_held"}, {16'h0, result_hi, result_lo}, {16'h0, held_hi, held_lo});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    //            name        op    a      b      lo     hi     dbz   done en
    vecs[0]  = '{"mul13x11",  1'b0, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 12,  11};
    vecs[1]  = '{"mul255x255",1'b0, 8'd255,8'd255,8'h01, 8'hFE, 1'b0, 256, 255};
    vecs[2]  = '{"mul77x0",   1'b0, 8'd77, 8'd0,  8'h00, 8'h00, 1'b0, 1,   0};
    vecs[3]  = '{"div200by7", 1'b1, 8'd200,8'd7,  8'd28, 8'd4,  1'b0, 30,  29};
    vecs[4]  = '{"div55by0",  1'b1, 8'h55, 8'd0,  8'hFF, 8'h55, 1'b1, 1,   0};
    vecs[5]  = '{"mul0x5",    1'b0, 8'd0,  8'd5,  8'h00, 8'h00, 1'b0, 6,   5};
    vecs[6]  = '{"mul16x16",  1'b0, 8'd16, 8'd16, 8'h00, 8'h01, 1'b0, 17,  16};
    vecs[7]  = '{"div255by1", 1'b1, 8'd255,8'd1,  8'd255,8'd0,  1'b0, 257, 256};
    vecs[8]  = '{"div5by9",   1'b1, 8'd5,  8'd9,  8'd0,  8'd5,  1'b0, 2,   1};
    vecs[9]  = '{"div0by3",   1'b1, 8'd0,  8'd3,  8'd0,  8'd0,  1'b0, 2,   1};
    vecs[10] = '{"div100by10",1'b1, 8'd100,8'd10, 8'd10, 8'd0,  1'b0, 12,  11};
    vecs[11] = '{"mul1x1",    1'b0, 8'd1,  8'd1,  8'h01, 8'h00, 1'b0, 2,   1};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    check("reset_results", {16'h0, result_hi, result_lo}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vecs[i], 0, 0);

    // Start pulses during MUL (cycle 3) and during DONE (cycle 12) are ignored.
    run_op('{"mul13x11_pokes", 1'b0, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 12, 11}, 3, 12);

    // Reset in cycle 5 of a 13 x 11 multiply aborts it without a done pulse.
    begin
      bit done_seen;
      done_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      a     = 8'd13;
      b     = 8'd11;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) done_seen = 1'b1;
        if (c == 5) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs_zero", all_outputs(), 32'd0);
      check("abort_results_zero", {16'h0, result_hi, result_lo}, 32'd0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done || busy) done_seen = 1'b1;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
    end

    run_op('{"mul3x4_after_abort", 1'b0, 8'd3, 8'd4, 8'd12, 8'd0, 1'b0, 5, 4}, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
